uart_tx_serializer: RTL and testbench

UART transmit serializer that consumes the divided baud clock `div_clk` from the clock divider stage and shifts parallel bytes onto the serial `tx` line. One rising edge of `div_clk` marks one bit time. With a 50 MHz `clk` that is one edge per 5209 cycles, about 9600 baud. The block accepts one character per valid/ready handshake and emits framed characters: start bit, LSB-first data, optional parity, stop bit(s).

---
 rtl/uart_tx_serializer_pkg.sv | 34 +++
 rtl/baud_edge_detect.sv | 26 ++
 rtl/uart_tx_serializer.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// uart_tx_serializer_pkg
//   Shared definitions for the UART transmit path, also imported by the
//   receiver: FSM state type, parity mode codes and a parity helper.
package uart_tx_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Parity bit for the low nbits of data. Odd mode inverts the XOR so the
  // total number of ones (data + parity) is odd.
  function automatic logic calc_parity(input logic [7:0]  data,
                                       input int unsigned nbits,
                                       input int unsigned mode);
    logic x;
    x = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < nbits) x = x ^ data[i];
    end
    if (mode == PAR_ODD)       return ~x;
    else if (mode == PAR_EVEN) return x;
    else                       return 1'b0;
  endfunction

endpackage

// File: rtl/baud_edge_detect.sv
// baud_edge_detect
//   Turns the divided baud clock level into a one-clk-wide tick on its
//   rising edge.
//   Ports:
//     clk       in  system clock
//     rst_n     in  asynchronous active-low reset
//     div_clk   in  baud clock level (sampled in clk domain)
//     baud_tick out one-cycle pulse per div_clk rising edge
module baud_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic div_clk,
  output logic baud_tick
);

  logic div_d;

  // Reset to 1 so a high div_clk at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_d <= 1'b1;
    else        div_d <= div_clk;
  end

  assign baud_tick = div_clk & ~div_d;

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Serializes one character per valid/ready handshake into a UART frame:
//   start bit, LSB-first data, optional parity, 1 or 2 stop bits. Each bit
//   lasts one baud_tick interval.
//   Parameters: DATA_BITS (5..8), PARITY (0 none, 1 odd, 2 even),
//               STOP_BITS (1 or 2).
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     div_clk  in   baud clock level from the divider
//     tx_data  in   character, bits [DATA_BITS-1:0] used
//     tx_valid in   tx_data valid
//     tx_ready out  can accept a character (IDLE)
//     tx       out  registered serial line, idles high
//     tx_busy  out  frame pending or in progress
//     tx_done  out  one-cycle pulse as the last stop bit completes
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       div_clk,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  logic       baud_tick;
  tx_state_e  state, state_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       par_bit, par_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       stop_cnt, stop_cnt_nxt;
  logic       tx_nxt;
  logic       done_nxt;
  logic       accept;

  baud_edge_detect u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_clk   (div_clk),
    .baud_tick (baud_tick)
  );

  assign tx_ready = (state == ST_IDLE);
  assign tx_busy  = ~tx_ready;
  assign accept   = tx_valid & tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      par_bit  <= par_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      tx       <= tx_nxt;
      tx_done  <= done_nxt;
    end
  end

  // Every output bit is computed here one cycle ahead and registered, so
  // tx changes on the clk edge that consumes the tick.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    par_nxt      = par_bit;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    tx_nxt       = tx;
    done_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        tx_nxt = 1'b1;
        if (accept) begin
          state_nxt = ST_SYNC;
          shreg_nxt = tx_data;
          par_nxt   = calc_parity(tx_data, DATA_BITS, PARITY);
        end
      end

      // A tick in the accept cycle is ignored; the frame aligns to the next.
      ST_SYNC: begin
        if (baud_tick) begin
          state_nxt = ST_START;
          tx_nxt    = 1'b0;
        end
      end

      ST_START: begin
        if (baud_tick) begin
          state_nxt   = ST_DATA;
          tx_nxt      = shreg[0];
          shreg_nxt   = {1'b0, shreg[7:1]};
          bit_cnt_nxt = '0;
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
            if (PARITY != PAR_NONE) begin
              state_nxt = ST_PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt = ST_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            tx_nxt      = shreg[0];
            shreg_nxt   = {1'b0, shreg[7:1]};
          end
        end
      end

      ST_PARITY: begin
        if (baud_tick) begin
          state_nxt = ST_STOP;
          tx_nxt    = 1'b1;
        end
      end

      ST_STOP: begin
        if (baud_tick) begin
          if (stop_cnt == LAST_STOP) begin
            state_nxt    = ST_IDLE;
            stop_cnt_nxt = 1'b0;
            done_nxt     = 1'b1;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
//   Directed bench for uart_tx_serializer. Four instances share clk, rst_n
//   and div_clk (16-clk period): 0 = 8N1, 1 = 8O1, 2 = 8E1, 3 = 5N2.
//   Expected frames are hand-written bit vectors, bit k = k-th bit on tx.
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst_n;
  logic       div_clk;
  logic       div_run;
  int         div_cnt;
  logic [7:0] tx_data_v [4];
  logic [3:0] tx_valid_v;
  logic [3:0] tx_ready_v;
  logic [3:0] tx_v;
  logic [3:0] tx_busy_v;
  logic [3:0] tx_done_v;

  int tests_run;
  int tests_failed;

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .div_clk(div_clk),
    .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]), .tx_ready(tx_ready_v[0]),
    .tx(tx_v[0]), .tx_busy(tx_busy_v[0]), .tx_done(tx_done_v[0]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .div_clk(div_clk),
    .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]), .tx_ready(tx_ready_v[1]),
    .tx(tx_v[1]), .tx_busy(tx_busy_v[1]), .tx_done(tx_done_v[1]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .div_clk(div_clk),
    .tx_data(tx_data_v[2]), .tx_valid(tx_valid_v[2]), .tx_ready(tx_ready_v[2]),
    .tx(tx_v[2]), .tx_busy(tx_busy_v[2]), .tx_done(tx_done_v[2]));

  uart_tx_serializer #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_5n2 (
    .clk(clk), .rst_n(rst_n), .div_clk(div_clk),
    .tx_data(tx_data_v[3]), .tx_valid(tx_valid_v[3]), .tx_ready(tx_ready_v[3]),
    .tx(tx_v[3]), .tx_busy(tx_busy_v[3]), .tx_done(tx_done_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // div_clk moves on the falling clk edge, away from the sampling edge.
  initial begin
    div_clk = 1'b0;
    div_cnt = 0;
  end
  always @(negedge clk) begin
    if (div_run) begin
      if (div_cnt == 7) begin
        div_cnt = 0;
        div_clk = ~div_clk;
      end else begin
        div_cnt = div_cnt + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a character and hold valid until the instance leaves IDLE.
  task automatic send(input int idx, input logic [7:0] data);
    int w;
    w = 0;
    @(negedge clk);
    tx_data_v[idx]  = data;
    tx_valid_v[idx] = 1'b1;
    @(negedge clk);
    while (tx_ready_v[idx] === 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    tx_valid_v[idx] = 1'b0;
    check($sformatf("accept%0d", idx), 32'(tx_ready_v[idx]), 32'd0);
  endtask

  // Wait for the start bit, then check the first and last cycle of every
  // bit period and the tx_done pulse right after the final bit period.
  task automatic expect_frame(input int idx, input logic [15:0] bits, input int n,
                              input string tag, output int waited);
    int w;
    w = 0;
    @(negedge clk);
    while (tx_v[idx] !== 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    waited = w;
    if (tx_v[idx] !== 1'b0) begin
      check({tag, "_start_timeout"}, 32'(tx_v[idx]), 32'd0);
      return;
    end
    for (int k = 0; k <= 16*n + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) check({tag, "_busy"}, 32'(tx_busy_v[idx]), 32'd1);
      if (k < 16*n && (k % 16 == 0 || k % 16 == 15))
        check($sformatf("%s_bit%0d_c%0d", tag, k/16, k%16),
              32'(tx_v[idx]), 32'(bits[k/16]));
      if (k == 16*n - 1) check({tag, "_done_early"}, 32'(tx_done_v[idx]), 32'd0);
      if (k == 16*n) begin
        check({tag, "_done"},  32'(tx_done_v[idx]),  32'd1);
        check({tag, "_ready"}, 32'(tx_ready_v[idx]), 32'd1);
        check({tag, "_idle"},  32'(tx_v[idx]),       32'd1);
      end
      if (k == 16*n + 1) check({tag, "_done_width"}, 32'(tx_done_v[idx]), 32'd0);
    end
  endtask

  initial begin
    int gap;
    int w;
    logic seen;

    tests_run    = 0;
    tests_failed = 0;
    div_run      = 1'b1;
    rst_n        = 1'b0;
    tx_valid_v   = '0;
    for (int i = 0; i < 4; i++) tx_data_v[i] = '0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx%0d", i),    32'(tx_v[i]),       32'd1);
      check($sformatf("rst_ready%0d", i), 32'(tx_ready_v[i]), 32'd1);
      check($sformatf("rst_busy%0d", i),  32'(tx_busy_v[i]),  32'd0);
      check($sformatf("rst_done%0d", i),  32'(tx_done_v[i]),  32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_tx", 32'(tx_v[0]), 32'd1);

    // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
    send(0, 8'h55);
    expect_frame(0, 16'h02AA, 10, "f55", gap);

    // 0x07: data 1,1,1,0,0,0,0,0; odd parity 0, even parity 1
    send(1, 8'h07);
    expect_frame(1, 16'h040E, 11, "f07odd", gap);
    send(2, 8'h07);
    expect_frame(2, 16'h060E, 11, "f07even", gap);

    // 5N2 0x1F: 0,1,1,1,1,1,1,1
    send(3, 8'h1F);
    expect_frame(3, 16'h00FE, 8, "f1F5n2", gap);

    // Back-to-back 0xA5, 0x3C with valid held; second start comes on the
    // first tick after the IDLE/done cycle.
    @(negedge clk);
    fork
      begin
        tx_data_v[0]  = 8'hA5;
        tx_valid_v[0] = 1'b1;
        w = 0;
        @(negedge clk);
        while (tx_ready_v[0] === 1'b1 && w < 100) begin @(negedge clk); w++; end
        tx_data_v[0] = 8'h3C;
        w = 0;
        while (tx_ready_v[0] === 1'b0 && w < 400) begin @(negedge clk); w++; end
        w = 0;
        @(negedge clk);
        while (tx_ready_v[0] === 1'b1 && w < 100) begin @(negedge clk); w++; end
        tx_valid_v[0] = 1'b0;
      end
      begin
        expect_frame(0, 16'h034A, 10, "b2b_A5", gap);
        expect_frame(0, 16'h0278, 10, "b2b_3C", gap);
        check("b2b_gap", 32'(gap), 32'd14);
      end
    join

    // 0x00 frame with a 0xFF pulse during DATA: pulse ignored
    send(0, 8'h00);
    fork
      expect_frame(0, 16'h0200, 10, "ign00", gap);
      begin
        w = 0;
        while (tx_v[0] !== 1'b0 && w < 100) begin @(negedge clk); w++; end
        repeat (40) @(negedge clk);
        check("ign_ready_low", 32'(tx_ready_v[0]), 32'd0);
        tx_data_v[0]  = 8'hFF;
        tx_valid_v[0] = 1'b1;
        @(negedge clk);
        tx_valid_v[0] = 1'b0;
        tx_data_v[0]  = 8'h00;
      end
    join
    seen = 1'b0;
    repeat (48) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || tx_busy_v[0] !== 1'b0) seen = 1'b1;
    end
    check("ign_no_second", 32'(seen), 32'd0);

    // Reset during data bit 3 of a 0x00 frame
    send(0, 8'h00);
    w = 0;
    @(negedge clk);
    while (tx_v[0] !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    repeat (16*4 + 8) @(negedge clk);
    check("rst_mid_pre_tx", 32'(tx_v[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_async", 32'(tx_v[0]),       32'd1);
    check("rst_mid_ready",    32'(tx_ready_v[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (64) begin
      @(negedge clk);
      if (tx_done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) seen = 1'b1;
    end
    check("rst_mid_quiet", 32'(seen), 32'd0);
    check("rst_mid_ready_after", 32'(tx_ready_v[0]), 32'd1);
    send(0, 8'h81);
    expect_frame(0, 16'h0302, 10, "f81", gap);

    // div_clk stuck: frame waits in SYNC with tx high, resumes on restart
    @(negedge clk);
    div_run = 1'b0;
    send(0, 8'h3C);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1) seen = 1'b1;
    end
    check("stuck_tx_high", 32'(seen), 32'd0);
    check("stuck_busy",    32'(tx_busy_v[0]), 32'd1);
    div_run = 1'b1;
    expect_frame(0, 16'h0278, 10, "stuck3C", gap);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
